// File: rtl/shift_left_if.sv
`default_nettype none
// shift_left_if: operand/result bundle between a requester and shift_left.
// Revision 1.0 -- flag signals present only when SHIFT_LEFT_FLAGS_EN is defined.
interface shift_left_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic [N-1:0] result;
`ifdef SHIFT_LEFT_FLAGS_EN
    logic         overflow;
    logic         zero;

    modport master (output in_valid, a, b, input out_valid, result, overflow, zero);
    modport slave  (input in_valid, a, b, output out_valid, result, overflow, zero);
`else
    modport master (output in_valid, a, b, input out_valid, result);
    modport slave  (input in_valid, a, b, output out_valid, result);
`endif
endinterface
`default_nettype wire

// File: rtl/shift_left.sv
`default_nettype none
// shift_left: registered logical left shifter (a << b, truncated to N bits), 1-cycle latency.
// Revision 1.0 -- optional overflow/zero flags via SHIFT_LEFT_FLAGS_EN.
module shift_left #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_left_if.slave bus
);
    localparam int STAGES = $clog2(N);

    logic [N-1:0] stage_val [0:STAGES];
    logic         stage_ovf [0:STAGES];
    logic         big_shift;
    logic [N-1:0] result_d;
    logic [N-1:0] result_q;
    logic         out_valid_q;

    assign stage_val[0] = bus.a;
    assign stage_ovf[0] = 1'b0;

    // Stage k shifts by 2^k; the bits it pushes off the top feed the overflow OR.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int SH = 1 << k;
            assign stage_val[k+1] = bus.b[k] ? {stage_val[k][N-1-SH:0], {SH{1'b0}}}
                                             : stage_val[k];
            assign stage_ovf[k+1] = stage_ovf[k] | (bus.b[k] & (|stage_val[k][N-1 -: SH]));
        end
    endgenerate

    // Any amount bit above the barrel range means b >= N: everything is shifted out.
    assign big_shift = |bus.b[N-1:STAGES];
    assign result_d  = big_shift ? '0 : stage_val[STAGES];

`ifdef SHIFT_LEFT_FLAGS_EN
    logic overflow_d;
    logic zero_d;
    logic overflow_q;
    logic zero_q;

    assign overflow_d = big_shift ? (|bus.a) : stage_ovf[STAGES];
    assign zero_d     = (result_d == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef SHIFT_LEFT_FLAGS_EN
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q   <= result_d;
`ifdef SHIFT_LEFT_FLAGS_EN
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
`endif
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
`ifdef SHIFT_LEFT_FLAGS_EN
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
`else
    logic unused_ok;
    assign unused_ok = stage_ovf[STAGES];
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_left.sv
`default_nettype none
// tb_shift_left: table-driven, directed and randomized checks of shift_left (N = 8).
// Revision 1.0
module tb_shift_left;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    shift_left_if #(.N(N)) bus ();

    shift_left #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        logic       zro;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic ovf, input logic zro);
`ifdef SHIFT_LEFT_FLAGS_EN
        check({name, ".overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
        check({name, ".zero"},     {31'd0, bus.zero},     {31'd0, zro});
`else
        if (ovf === 1'bx || zro === 1'bx) n_checks += 0;
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_res(input int unsigned a, input int unsigned b);
        longint unsigned prod;
        if (b >= N) return 8'h00;
        prod = longint'(a) * (64'd1 << b);
        return 8'(prod % 256);
    endfunction

    function automatic logic ref_ovf(input int unsigned a, input int unsigned b);
        longint unsigned prod;
        if (b >= N) return (a != 0);
        prod = longint'(a) * (64'd1 << b);
        return (prod >= 256);
    endfunction

    vec_t       vecs [11];
    logic [7:0] exp_res;
    logic       exp_ovf;
    logic       exp_zro;
    logic       exp_vld;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0]  = '{8'h96, 8'h02, 8'h58, 1'b1, 1'b0};
        vecs[1]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{8'hFF, 8'h07, 8'h80, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF, 8'h08, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'h01, 8'h08, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{8'h01, 8'h01, 8'h02, 1'b0, 1'b0};
        vecs[9]  = '{8'h01, 8'h02, 8'h04, 1'b0, 1'b0};
        vecs[10] = '{8'h01, 8'h03, 8'h08, 1'b0, 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result",    {24'd0, bus.result},   32'd0);
        check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_flags("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        check("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Table applied back-to-back: also covers streaming with no bubbles.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.result", i),    {24'd0, bus.result},    {24'd0, vecs[i].res});
            check($sformatf("vec%0d.out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check_flags($sformatf("vec%0d", i), vecs[i].ovf, vecs[i].zro);
        end

        // Single pulse followed by hold with changing operands.
        step(1'b0, 8'h00, 8'h00);
        check("gap.out_valid", {31'd0, bus.out_valid}, 32'd0);
        step(1'b1, 8'h96, 8'h02);
        check("pulse.result",    {24'd0, bus.result},    32'h58);
        check("pulse.out_valid", {31'd0, bus.out_valid}, 32'd1);
        check_flags("pulse", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom_range(0, 7)));
            check($sformatf("hold%0d.result", i),    {24'd0, bus.result},    32'h58);
            check($sformatf("hold%0d.out_valid", i), {31'd0, bus.out_valid}, 32'd0);
            check_flags($sformatf("hold%0d", i), 1'b1, 1'b0);
        end

        // Asynchronous reset between edges, then recovery.
        step(1'b1, 8'h96, 8'h02);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.result",    {24'd0, bus.result},    32'd0);
        check("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_flags("arst", 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h03, 8'h01);
        check("post_rst.result",    {24'd0, bus.result},    32'h06);
        check("post_rst.out_valid", {31'd0, bus.out_valid}, 32'd1);
        check_flags("post_rst", 1'b0, 1'b0);

        // Randomized traffic against the arithmetic model.
        exp_res = 8'h06;
        exp_ovf = 1'b0;
        exp_zro = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic       v;
            logic [7:0] ra;
            logic [7:0] rb;
            v  = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            step(v, ra, rb);
            exp_vld = v;
            if (v) begin
                exp_res = ref_res(ra, rb);
                exp_ovf = ref_ovf(ra, rb);
                exp_zro = (exp_res == 8'h00);
            end
            check($sformatf("rnd%0d.result", i),    {24'd0, bus.result},    {24'd0, exp_res});
            check($sformatf("rnd%0d.out_valid", i), {31'd0, bus.out_valid}, {31'd0, exp_vld});
            check_flags($sformatf("rnd%0d", i), exp_ovf, exp_zro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
